// File: rtl/bf_pkg.sv
// Shared types and constants for the brainfuck execution core.
package bf_pkg;

  typedef enum logic [3:0] {
    FETCH,
    EXEC,
    LD_WAIT,
    LD_CAP,
    OUT,
    IN,
    SC_WAIT,
    SC_CHK,
    HALT
  } state_t;

  localparam logic [7:0] OP_INC   = 8'h2B;  // '+'
  localparam logic [7:0] OP_DEC   = 8'h2D;  // '-'
  localparam logic [7:0] OP_RIGHT = 8'h3E;  // '>'
  localparam logic [7:0] OP_LEFT  = 8'h3C;  // '<'
  localparam logic [7:0] OP_JZ    = 8'h5B;  // '['
  localparam logic [7:0] OP_JNZ   = 8'h5D;  // ']'
  localparam logic [7:0] OP_OUT   = 8'h2E;  // '.'
  localparam logic [7:0] OP_IN    = 8'h2C;  // ','
  localparam logic [7:0] OP_END   = 8'h00;  // program terminator

  localparam logic [15:0] DATA_BASE_DEF = 16'h0100;

endpackage

// File: rtl/bf_core.sv
// Brainfuck execution core: fetches program bytes on memory channel 2 and
// operates on a 256-cell tape through memory channel 1. Tape cell under the
// pointer is mirrored in cell_q so '+'/'-'/'['/']' never wait on a read.
module bf_core
  import bf_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] DATA_BASE = ADDR_W'(DATA_BASE_DEF),
  parameter int                PC_W      = 8,
  parameter int                DEPTH_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic [ADDR_W-1:0] mem_addr2,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata1,
  input  logic [7:0]        mem_rdata2,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              halted,
  output logic              error
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [7:0]         ptr_q, ptr_d;
  logic [7:0]         cell_q, cell_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               fwd_q, fwd_d;
  logic               halted_q, halted_d;
  logic               error_q, error_d;

  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [PC_W-1:0]    PC_ONE    = PC_W'(1);

  assign mem_addr1 = DATA_BASE + ADDR_W'(ptr_q);
  assign mem_addr2 = ADDR_W'(pc_q);
  assign out_data  = cell_q;
  assign halted    = halted_q;
  assign error     = error_q;

  // State and datapath registers; reset restarts with a tape reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LD_WAIT;
      pc_q     <= '0;
      ptr_q    <= '0;
      cell_q   <= '0;
      depth_q  <= '0;
      fwd_q    <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ptr_q    <= ptr_d;
      cell_q   <= cell_d;
      depth_q  <= depth_d;
      fwd_q    <= fwd_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  // Next-state decode, tape write strobes and stream handshakes.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ptr_d     = ptr_q;
    cell_d    = cell_q;
    depth_d   = depth_q;
    fwd_d     = fwd_q;
    halted_d  = halted_q;
    error_d   = error_q;
    mem_we    = 1'b0;
    mem_wdata = cell_q;
    out_valid = 1'b0;
    in_ready  = 1'b0;

    case (state_q)
      FETCH: state_d = EXEC;

      EXEC: begin
        case (mem_rdata2)
          OP_INC, OP_DEC: begin
            cell_d    = (mem_rdata2 == OP_INC) ? cell_q + 8'd1 : cell_q - 8'd1;
            mem_we    = 1'b1;
            mem_wdata = cell_d;
            pc_d      = pc_q + PC_ONE;
            state_d   = FETCH;
          end
          OP_RIGHT, OP_LEFT: begin
            ptr_d   = (mem_rdata2 == OP_RIGHT) ? ptr_q + 8'd1 : ptr_q - 8'd1;
            pc_d    = pc_q + PC_ONE;
            state_d = LD_WAIT;
          end
          OP_OUT: state_d = OUT;
          OP_IN:  state_d = IN;
          OP_JZ: begin
            pc_d = pc_q + PC_ONE;
            if (cell_q == 8'd0) begin
              depth_d = DEPTH_ONE;
              fwd_d   = 1'b1;
              state_d = SC_WAIT;
            end else begin
              state_d = FETCH;
            end
          end
          OP_JNZ: begin
            if (cell_q != 8'd0) begin
              depth_d = DEPTH_ONE;
              fwd_d   = 1'b0;
              pc_d    = pc_q - PC_ONE;
              state_d = SC_WAIT;
            end else begin
              pc_d    = pc_q + PC_ONE;
              state_d = FETCH;
            end
          end
          OP_END: begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
          default: begin
            pc_d    = pc_q + PC_ONE;
            state_d = FETCH;
          end
        endcase
      end

      LD_WAIT: state_d = LD_CAP;

      LD_CAP: begin
        cell_d  = mem_rdata1;
        state_d = FETCH;
      end

      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pc_d    = pc_q + PC_ONE;
          state_d = FETCH;
        end
      end

      IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cell_d    = in_data;
          mem_we    = 1'b1;
          mem_wdata = in_data;
          pc_d      = pc_q + PC_ONE;
          state_d   = FETCH;
        end
      end

      SC_WAIT: state_d = SC_CHK;

      SC_CHK: begin
        if (fwd_q) begin
          if (mem_rdata2 == OP_END) begin
            error_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d = pc_q + PC_ONE;
            if (mem_rdata2 == OP_JNZ && depth_q == DEPTH_ONE) begin
              depth_d = '0;
              state_d = FETCH;
            end else begin
              if (mem_rdata2 == OP_JZ)       depth_d = depth_q + DEPTH_ONE;
              else if (mem_rdata2 == OP_JNZ) depth_d = depth_q - DEPTH_ONE;
              state_d = SC_WAIT;
            end
          end
        end else begin
          if (mem_rdata2 == OP_JZ && depth_q == DEPTH_ONE) begin
            depth_d = '0;
            pc_d    = pc_q + PC_ONE;
            state_d = FETCH;
          end else begin
            if (mem_rdata2 == OP_JNZ)     depth_d = depth_q + DEPTH_ONE;
            else if (mem_rdata2 == OP_JZ) depth_d = depth_q - DEPTH_ONE;
            if (pc_q == '0) begin
              error_d  = 1'b1;
              halted_d = 1'b1;
              state_d  = HALT;
            end else begin
              pc_d    = pc_q - PC_ONE;
              state_d = SC_WAIT;
            end
          end
        end
      end

      HALT: halted_d = 1'b1;

      default: state_d = HALT;
    endcase
  end

endmodule

// File: tb/tb_bf_core.sv
// Testbench for bf_core: dual-port memory model, randomized stream stalls,
// reference interpreter feeding an output scoreboard.
module tb_bf_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [15:0] mem_addr1, mem_addr2;
  logic [7:0]  mem_wdata, mem_rdata1, mem_rdata2;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        halted, error;

  always #5 clk = ~clk;

  bf_core #(
    .ADDR_W   (16),
    .DATA_BASE(16'h0100),
    .PC_W     (8),
    .DEPTH_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_we    (mem_we),
    .mem_addr1 (mem_addr1),
    .mem_addr2 (mem_addr2),
    .mem_wdata (mem_wdata),
    .mem_rdata1(mem_rdata1),
    .mem_rdata2(mem_rdata2),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .halted    (halted),
    .error     (error)
  );

  // Memory model: program at 0x000-0x0FF, tape at 0x100-0x1FF.
  logic [7:0] mem [0:511];
  logic [7:0] img [0:511];
  logic       ld_all = 1'b0;

  always @(posedge clk) begin
    if (ld_all) begin
      for (int i = 0; i < 512; i++) mem[i] <= img[i];
    end else if (mem_we) begin
      mem[mem_addr1[8:0]] <= mem_wdata;
    end
    mem_rdata1 <= (mem_we && !ld_all) ? mem_wdata : mem[mem_addr1[8:0]];
    mem_rdata2 <= mem[mem_addr2[8:0]];
  end

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_out[$];
  logic [7:0] in_src[$];
  logic [7:0] in_ref[$];
  logic [7:0] ref_tape [0:255];
  bit         ref_err;
  int         in_lat = 0, out_lat = 0;
  int         hs_cnt = 0, iw_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference interpreter: plain brainfuck semantics over img.
  task automatic ref_run();
    int pc = 0, ptr = 0, d, steps = 0, ii = 0;
    logic [7:0] op;
    for (int i = 0; i < 256; i++) ref_tape[i] = img[256+i];
    ref_err = 1'b0;
    while (steps < 100000) begin
      steps++;
      op = img[pc];
      if (op == 8'h00) break;
      case (op)
        "+": ref_tape[ptr] = ref_tape[ptr] + 8'd1;
        "-": ref_tape[ptr] = ref_tape[ptr] - 8'd1;
        ">": ptr = (ptr + 1) % 256;
        "<": ptr = (ptr + 255) % 256;
        ".": exp_out.push_back(ref_tape[ptr]);
        ",": begin
          ref_tape[ptr] = (ii < in_ref.size()) ? in_ref[ii] : 8'h00;
          ii++;
        end
        "[": if (ref_tape[ptr] == 8'd0) begin
          d = 1;
          while (d > 0) begin
            pc = (pc + 1) % 256;
            if (img[pc] == 8'h00) begin ref_err = 1'b1; break; end
            if (img[pc] == "[") d++;
            if (img[pc] == "]") d--;
          end
        end
        "]": if (ref_tape[ptr] != 8'd0) begin
          d = 1;
          while (d > 0) begin
            if (pc == 0) begin ref_err = 1'b1; break; end
            pc--;
            if (img[pc] == "]") d++;
            if (img[pc] == "[") d--;
          end
        end
        default: ;
      endcase
      if (ref_err) break;
      pc = (pc + 1) % 256;
    end
  endtask

  task automatic load_and_reset(input string p, input bit rnd_tape, input bit keep_tape);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) img[i] = (i < p.len()) ? p[i] : 8'h00;
    for (int i = 0; i < 256; i++)
      img[256+i] = keep_tape ? mem[256+i] : (rnd_tape ? 8'($urandom) : 8'h00);
    ld_all = 1'b1;
    @(posedge clk); #1;
    ld_all = 1'b0;
    exp_out.delete();
    in_src = in_ref;
    ref_run();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    int mism = 0;
    while (!halted && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " halted"}, int'(halted), 1);
    chk({name, " error"}, int'(error), int'(ref_err));
    chk({name, " we idle"}, int'(mem_we), 0);
    repeat (2) @(negedge clk);
    chk({name, " outputs left"}, exp_out.size(), 0);
    for (int i = 0; i < 256; i++) if (mem[256+i] !== ref_tape[i]) mism++;
    chk({name, " tape"}, mism, 0);
  endtask

  task automatic run(input string name, input string p, input bit rnd_tape);
    load_and_reset(p, rnd_tape, 1'b0);
    wait_halt(name);
  endtask

  // Stream driver: in_valid/out_ready asserted after a configurable wait.
  initial begin : io_drv
    int in_wait = 0, out_wait = 0;
    bit ihs, ohs, iseen, oseen;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    forever begin
      @(negedge clk);
      ihs = in_valid && in_ready;
      ohs = out_valid && out_ready;
      iseen = in_ready;
      oseen = out_valid;
      @(posedge clk); #1;
      if (rst) begin in_wait = 0; out_wait = 0; end
      if (ihs) begin
        if (in_src.size() > 0) void'(in_src.pop_front());
        in_wait = 0;
      end else if (iseen) in_wait++;
      if (ohs) out_wait = 0;
      else if (oseen) out_wait++;
      if (in_lat == 0) in_valid = in_src.size() > 0;
      else in_valid = (in_src.size() > 0) && iseen && !ihs && (in_wait >= in_lat);
      in_data = (in_src.size() > 0) ? in_src[0] : 8'h00;
      out_ready = (out_lat == 0) ? 1'b1 : (oseen && !ohs && (out_wait >= out_lat));
    end
  end

  // Output monitor: scoreboard pop on handshake, stability while stalled.
  initial begin : mon
    logic       pv, phs;
    logic [7:0] pd, e;
    pv = 1'b0; phs = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; phs = 1'b0; hs_cnt = 0; iw_cnt = 0;
        continue;
      end
      if (in_ready && !in_valid) iw_cnt++;
      if (out_valid && pv && !phs) chk("out_data stable", int'(out_data), int'(pd));
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_out.size() == 0) chk("extra output", exp_out.size(), 1);
        else begin
          e = exp_out.pop_front();
          chk("out_data", int'(out_data), int'(e));
        end
      end
      pv = out_valid;
      phs = out_valid && out_ready;
      pd = out_data;
    end
  end

  initial begin : main
    string toks [0:8];
    string p;
    int    len, ncomma;
    rst = 1'b1;
    for (int i = 0; i < 512; i++) img[i] = 8'h00;
    repeat (2) @(negedge clk);

    chk("rst mem_we", int'(mem_we), 0);
    chk("rst mem_addr1", int'(mem_addr1), 'h100);
    chk("rst mem_addr2", int'(mem_addr2), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst in_ready", int'(in_ready), 0);
    chk("rst halted", int'(halted), 0);
    chk("rst error", int'(error), 0);

    in_ref.delete();
    run("t1", "+++.", 1'b0);
    chk("t1 handshakes", hs_cnt, 1);
    chk("t1 tape100", int'(mem[256]), 3);

    run("t2", "<+>-.", 1'b0);
    chk("t2 tape1ff", int'(mem[511]), 1);
    chk("t2 tape100", int'(mem[256]), 'hFF);

    run("t3", "++[>+++<-]>.", 1'b0);
    chk("t3 tape100", int'(mem[256]), 0);
    chk("t3 tape101", int'(mem[257]), 6);

    run("t4a", "[+.[-]].", 1'b0);
    chk("t4a handshakes", hs_cnt, 1);
    run("t4b", "+]", 1'b0);
    chk("t4b error", int'(error), 1);

    in_ref.delete();
    in_ref.push_back(8'h41);
    in_lat = 5; out_lat = 3;
    run("t5", ",.", 1'b0);
    chk("t5 in_ready wait", iw_cnt, 5);
    chk("t5 handshakes", hs_cnt, 1);
    chk("t5 tape100", int'(mem[256]), 'h41);
    in_lat = 0; out_lat = 0;
    in_ref.delete();

    load_and_reset("++[>+++<-]>.", 1'b0, 1'b0);
    repeat ($urandom_range(15, 60)) @(negedge clk);
    chk("t6 running", int'(halted), 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t6 rst mem_we", int'(mem_we), 0);
    chk("t6 rst mem_addr1", int'(mem_addr1), 'h100);
    chk("t6 rst mem_addr2", int'(mem_addr2), 0);
    chk("t6 rst out_valid", int'(out_valid), 0);
    chk("t6 rst in_ready", int'(in_ready), 0);
    chk("t6 rst halted", int'(halted), 0);
    chk("t6 rst error", int'(error), 0);
    load_and_reset("++[>+++<-]>.", 1'b0, 1'b1);
    wait_halt("t6 rerun");

    toks = '{"+", "-", ">", "<", ".", ",", "x", "[-]", "++"};
    for (int k = 0; k < 10; k++) begin
      p = "";
      ncomma = 0;
      len = $urandom_range(8, 30);
      for (int t = 0; t < len; t++) p = {p, toks[$urandom_range(0, 8)]};
      in_ref.delete();
      for (int i = 0; i < p.len(); i++) if (p[i] == ",") ncomma++;
      for (int i = 0; i < ncomma; i++) in_ref.push_back(8'($urandom));
      in_lat = $urandom_range(0, 3);
      out_lat = $urandom_range(0, 3);
      run($sformatf("rand%0d", k), p, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bf_core.md
Name: bf_core

Overview:
Execution core that is the initiator on both channels of the dual-port byte memory.
- Drives channel 2 (read-only) for instruction fetch.
- Drives channel 1 (read/write) for the data tape.
- Interprets brainfuck bytes from program space 0x0000–0x00FF against a 256-cell tape at DATA_BASE.
- Exposes valid/ready byte streams for '.' and ','.

Parameters:
ADDR_W, 16, memory address width; matches memory port width
DATA_BASE, 16'h0100, tape base address; cell address = DATA_BASE + ptr
PC_W, 8, program counter width (256-byte program space)
DEPTH_W, 8, bracket-scan nesting counter width

Ports:
clk  in  1  rising-edge clock, shared with memory
rst  in  1  asynchronous, active-high reset
mem_we  out  1  channel-1 write enable
mem_addr1  out  ADDR_W  channel-1 address = DATA_BASE + ptr (combinational from ptr)
mem_addr2  out  ADDR_W  channel-2 address = zero-extended pc (combinational from pc)
mem_wdata  out  8  channel-1 write data
mem_rdata1  in  8  channel-1 registered read data
mem_rdata2  in  8  channel-2 registered read data
out_valid  out  1  output byte valid
out_data  out  8  output byte
out_ready  in  1  sink accepts output byte
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_ready  out  1  core accepts input byte
halted  out  1  execution stopped; sticky until rst
error  out  1  unmatched bracket detected; sticky until rst

Behaviour:
- Memory contract:
  - Memory samples addresses at posedge. rdata is valid in the cycle after the edge that sampled the address.
  - Writes are write-first.
  - Memory has no reset.
- Registers:
  - pc (PC_W), ptr (8), cell (8, mirror of tape[ptr]), depth (DEPTH_W), state, halted, error.
- Reset values:
  - pc=0, ptr=0, cell=0, depth=0, state=LD_WAIT.
  - mem_we=0, mem_addr1=0x0100, mem_addr2=0x0000.
  - out_valid=0, in_ready=0, halted=0, error=0.
  - Reset mid-operation aborts the in-flight op. The first action after reset is reloading cell from the tape; tape contents persist.
- States and transitions:
  - FETCH: wait one cycle for rdata2 → EXEC.
  - EXEC: decode rdata2.
    - '+'/'-': cell±1 mod 256; mem_we=1 with mem_wdata=new value this cycle; pc++; → FETCH.
    - '>'/'<': ptr±1 mod 256 (0xFF→0x00 and 0x00→0xFF wrap); pc++; → LD_WAIT.
    - '.': → OUT.
    - ',': → IN.
    - '[': if cell==0, depth=1, pc++, → SC_WAIT(fwd); else pc++, → FETCH.
    - ']': if cell!=0, depth=1, pc--, → SC_WAIT(bwd); else pc++, → FETCH.
    - 0x00: → HALT.
    - Any other byte: NOP; pc++; → FETCH.
  - LD_WAIT → LD_CAP: cell<=rdata1 → FETCH. A '>'/'<' therefore costs 4 cycles including its fetch.
  - OUT: out_valid=1, out_data=cell, held stable until out_valid&out_ready. On that edge: pc++, → FETCH.
  - IN: in_ready=1. On in_valid&in_ready: cell<=in_data, mem_we=1, mem_wdata=in_data that cycle, pc++, → FETCH.
  - SC_WAIT → SC_CHK: 2 cycles per scanned byte.
    - Forward scan: '[' depth++; ']' depth--. If depth reaches 0: pc=match+1, → FETCH. 0x00 → error=1, → HALT. Otherwise pc++.
    - Backward scan: ']' depth++; '[' depth--. If depth reaches 0: pc=match+1, → FETCH. If pc==0 with no match: error=1, → HALT. Otherwise pc--.
  - HALT: halted=1, all strobes 0, pc frozen; exit only via rst.
- mem_we is asserted only in the exact cycles listed above.
- pc++ from 0xFF wraps to 0x00.

Decomposition:
- Package bf_pkg:
  - state enum (FETCH, EXEC, LD_WAIT, LD_CAP, OUT, IN, SC_WAIT, SC_CHK, HALT).
  - opcode constants: 0x2B '+', 0x2D '-', 0x3E '>', 0x3C '<', 0x5B '[', 0x5D ']', 0x2E '.', 0x2C ',', 0x00 end.
  - DATA_BASE default.
- No sub-module. The FSM and datapath are a single unit.

Test Plan:
1. Program "+++." then 0x00; out_ready=1 → exactly one handshake with out_data=0x03; tape[0x100]=0x03; halted=1; error=0.
2. Program "<+>-." then 0x00 → tape[0x1FF]=0x01, tape[0x100]=0xFF, out_data=0xFF (ptr wrap both directions).
3. Program "++[>+++<-]>." then 0x00 → out_data=0x06; tape[0x100]=0x00; tape[0x101]=0x06; halted=1.
4. Program "[+.[-]]." with cell=0 → forward scan skips nested body; one output 0x00; error=0. Program "+]" → backward scan reaches pc 0 → error=1, halted=1.
5. Program ",." ; in_valid rises 5 cycles late with in_data=0x41; out_ready held low 3 cycles → in_ready stays high while waiting; out_data=0x41 stable while out_valid=1; single handshake; tape[0x100]=0x41.
6. Assert rst asynchronously mid-loop of scenario 3 → all outputs at reset values immediately; cell reloads from tape[0x100]; re-run completes without error.
